rf_wport_arbiter: RTL
=====================

// Module: rf_wport_arbiter
// PURPOSE
//  Shares the single DLX register-file write port (5-bit address, 32-bit data)
//  between core writeback and the image-sharpening unit. Core writes win by
//  default; sharpen results wait in a DEPTH-entry FIFO and drain on idle core
//  cycles. A starvation limit forces a drain. Hazard outputs flag reads of
//  registers with pending sharpen writes.
// PARAMETERS
//  DEPTH         4  sharpen FIFO entries; power of 2, >=2
//  STARVE_LIMIT  8  cycles the FIFO head may lose to core before HOLD_REQ; 0 = never
// PORTS
//  CLK       in   1   clock, all state on rising edge
//  RESET     in   1   synchronous, active-high reset
//  CORE_WE   in   1   core writeback request this cycle
//  CORE_WA   in   5   core destination register
//  CORE_WD   in   32  core write data
//  HOLD_REQ  out  1   core must hold its writeback: it is ignored this cycle, core re-presents it next cycle
//  SH_VALID  in   1   sharpen write offered
//  SH_READY  out  1   FIFO can accept; transfer when SH_VALID&SH_READY
//  SH_WA     in   5   sharpen destination register
//  SH_WD     in   32  sharpen write data
//  RF_WE     out  1   register-file write enable (registered)
//  RF_WA     out  5   register-file write address (registered)
//  RF_WD     out  32  register-file write data (registered)
//  RF_SRC    out  1   source of current write: 0 core, 1 sharpen
//  CHK_A     in   5   decode-stage read address A
//  CHK_B     in   5   decode-stage read address B
//  HAZ_A     out  1   CHK_A!=0 and matches a valid FIFO entry's WA
//  HAZ_B     out  1   as HAZ_A for CHK_B
//  PEND_CNT  out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  - Reset (sync): FIFO emptied, pointers/count/starve counter = 0; RF_WE=0,
//    RF_WA=0, RF_WD=0, RF_SRC=0. SH_READY=0 and HOLD_REQ=0 while RESET=1.
//    Reset mid-operation discards all pending entries; no RF write follows.
//  - SH_READY = (PEND_CNT<DEPTH) & !RESET, from registered count only.
//  - Accepted sharpen writes with SH_WA=0 are consumed but not enqueued.
//    Core writes with CORE_WA=0 are treated as CORE_WE=0. R0 is never written.
//  - Grant per cycle, from registered state and current inputs:
//     1. HOLD_REQ=1 (FIFO non-empty, STARVE_LIMIT!=0, starve==STARVE_LIMIT):
//        pop head; the core request is ignored.
//     2. else valid core write: issue core.
//     3. else FIFO non-empty: pop head.
//     4. else no write.
//  - The granted write appears on RF_* at the next edge (latency 1), with
//    RF_WE=1 for exactly one cycle per grant.
//  - Starve counter: +1 each cycle the FIFO is non-empty and core wins. It
//    clears on any pop or when the FIFO is empty and saturates at STARVE_LIMIT.
//  - Push and pop in the same cycle: count is unchanged. A pop sees only the
//    pre-push head, so a push into an empty FIFO cannot issue the same cycle.
//    The minimum sharpen latency is accept edge +1 to RF_WE.
//  - Pointers wrap modulo DEPTH; the FIFO issues in order (FIFO order).
//  - HAZ_A/HAZ_B are combinational over valid entries. An entry popped this
//    cycle still flags; it is in flight to RF_* for the next edge.
// TESTING
//  - Reset: assert RESET 2 cycles mid-traffic -> RF_WE=0, PEND_CNT=0, SH_READY=0 then 1.
//  - Core only: CORE_WE=1, WA=5, WD=0xDEADBEEF -> next cycle RF_WE=1, RF_WA=5, RF_SRC=0.
//  - Sharpen idle drain: push WA=7, WD=0x11 with core idle -> RF_WE at accept+1, RF_SRC=1, PEND_CNT back to 0.
//  - Full/backpressure: core busy, push 4 (DEPTH=4) -> SH_READY=0; 5th offer is held; FIFO drains in order when core idles.
//  - Starvation: 1 entry pending, core busy continuously, STARVE_LIMIT=8 -> HOLD_REQ=1 on the 9th cycle, sharpen write issues, core write follows a cycle later.
//  - Hazard/R0: pending WA=3, CHK_A=3 -> HAZ_A=1. Core write to WA=0 and sharpen push to WA=0 -> no RF_WE, PEND_CNT unchanged.

Source files
------------

// File: rtl/rf_wport_arbiter.sv
// Shares the register-file write port between core writeback and a queued
// sharpen-unit stream, with starvation relief and pending-write hazard flags.
module rf_wport_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CORE_WE,
    input  logic [4:0]                 CORE_WA,
    input  logic [31:0]                CORE_WD,
    output logic                       HOLD_REQ,
    input  logic                       SH_VALID,
    output logic                       SH_READY,
    input  logic [4:0]                 SH_WA,
    input  logic [31:0]                SH_WD,
    output logic                       RF_WE,
    output logic [4:0]                 RF_WA,
    output logic [31:0]                RF_WD,
    output logic                       RF_SRC,
    input  logic [4:0]                 CHK_A,
    input  logic [4:0]                 CHK_B,
    output logic                       HAZ_A,
    output logic                       HAZ_B,
    output logic [$clog2(DEPTH+1)-1:0] PEND_CNT
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

    logic [4:0]       wa_mem_q [DEPTH];
    logic [4:0]       wa_mem_d [DEPTH];
    logic [31:0]      wd_mem_q [DEPTH];
    logic [31:0]      wd_mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_wa_q, rf_wa_d;
    logic [31:0]      rf_wd_q, rf_wd_d;
    logic             rf_src_q, rf_src_d;

    logic fifo_nonempty, core_valid, hold, ready, push, pop;

    // Grant decision: a saturated starve counter overrides the core's default priority.
    always_comb begin
        fifo_nonempty = (count_q != '0);
        core_valid    = CORE_WE && (CORE_WA != 5'd0);
        hold          = !RESET && fifo_nonempty && (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);
        ready         = !RESET && (count_q < FULL_CNT);
        push          = SH_VALID && ready && (SH_WA != 5'd0);
        pop           = fifo_nonempty && (hold || !core_valid);
    end

    always_comb begin
        wa_mem_d = wa_mem_q;
        wd_mem_d = wd_mem_q;
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        rf_we_d  = 1'b0;
        rf_wa_d  = rf_wa_q;
        rf_wd_d  = rf_wd_q;
        rf_src_d = rf_src_q;

        // Push never targets the head slot when popping: full blocks push, empty blocks pop.
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
            rf_we_d           = 1'b1;
            rf_wa_d           = wa_mem_q[rd_ptr_q];
            rf_wd_d           = wd_mem_q[rd_ptr_q];
            rf_src_d          = 1'b1;
        end else if (core_valid) begin
            rf_we_d  = 1'b1;
            rf_wa_d  = CORE_WA;
            rf_wd_d  = CORE_WD;
            rf_src_d = 1'b0;
        end

        if (push) begin
            wa_mem_d[wr_ptr_q] = SH_WA;
            wd_mem_d[wr_ptr_q] = SH_WD;
            valid_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // A non-empty FIFO that did not pop can only mean the core won this cycle.
        if (pop || !fifo_nonempty) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        HAZ_A = 1'b0;
        HAZ_B = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (wa_mem_q[i] == CHK_A)) HAZ_A = 1'b1;
            if (valid_q[i] && (wa_mem_q[i] == CHK_B)) HAZ_B = 1'b1;
        end
        HAZ_A = HAZ_A && (CHK_A != 5'd0);
        HAZ_B = HAZ_B && (CHK_B != 5'd0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                wa_mem_q[i] <= '0;
                wd_mem_q[i] <= '0;
            end
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            rf_we_q  <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
            rf_src_q <= 1'b0;
        end else begin
            wa_mem_q <= wa_mem_d;
            wd_mem_q <= wd_mem_d;
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            rf_we_q  <= rf_we_d;
            rf_wa_q  <= rf_wa_d;
            rf_wd_q  <= rf_wd_d;
            rf_src_q <= rf_src_d;
        end
    end

    assign HOLD_REQ = hold;
    assign SH_READY = ready;
    assign RF_WE    = rf_we_q;
    assign RF_WA    = rf_wa_q;
    assign RF_WD    = rf_wd_q;
    assign RF_SRC   = rf_src_q;
    assign PEND_CNT = count_q;
endmodule
